// File: rtl/linebuffer_3x3.sv
// linebuffer_3x3: 3x3 sliding-window generator for a raster-order pixel stream.
//
// One pixel is captured on every rising clk edge while rst_n is high. Two
// row delay lines supply the pixels from one and two rows back. Nine window
// registers hold the current 3x3 neighbourhood.
//
// Ports:
//   clk           - single clock, rising-edge active
//   rst_n         - asynchronous active-low reset; clears all state
//   ifmap_stream  - DATA_W-bit pixel input, one sample per clock
//   ifmap_3x3     - registered window; element 8 is the newest pixel
//                   (bottom-right), element 0 the oldest (top-left)
//   window_valid  - registered flag; high when the window lies fully
//                   inside the image (col >= 2 and row >= 2)
module linebuffer_3x3 #(
  parameter int DATA_W    = 16,
  parameter int IMG_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      ifmap_stream,
  output logic [8:0][DATA_W-1:0] ifmap_3x3,
  output logic                   window_valid
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

  // Row delay lines. After edge t, line1_reg[k] = p(t-k) and
  // line2_reg[k] = p(t-IMG_WIDTH-k). The last taps therefore present
  // p(t-IMG_WIDTH) and p(t-2*IMG_WIDTH) to the window at edge t.
  logic [DATA_W-1:0] line1_reg [IMG_WIDTH];
  logic [DATA_W-1:0] line2_reg [IMG_WIDTH];
  logic [DATA_W-1:0] win_reg   [9];

  logic [COL_W-1:0] col_reg, col_next;
  logic [1:0]       row_reg, row_next;
  logic             started_reg;
  logic             valid_reg, valid_next;

  // col_reg tracks the column of the most recent capture. The first capture
  // after reset is column 0, so counting starts only once a sample is held.
  always_comb begin
    col_next   = '0;
    row_next   = row_reg;
    valid_next = 1'b0;
    if (started_reg) begin
      if (col_reg == COL_LAST) begin
        col_next = '0;
        if (row_reg != 2'd2) begin
          row_next = row_reg + 2'd1;
        end
      end else begin
        col_next = col_reg + COL_W'(1);
      end
    end
    valid_next = (col_next >= COL_W'(2)) && (row_next == 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_WIDTH; i++) begin
        line1_reg[i] <= '0;
        line2_reg[i] <= '0;
      end
      for (int i = 0; i < 9; i++) begin
        win_reg[i] <= '0;
      end
      col_reg     <= '0;
      row_reg     <= '0;
      started_reg <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      line1_reg[0] <= ifmap_stream;
      line2_reg[0] <= line1_reg[IMG_WIDTH-1];
      for (int i = 1; i < IMG_WIDTH; i++) begin
        line1_reg[i] <= line1_reg[i-1];
        line2_reg[i] <= line2_reg[i-1];
      end
      // Bottom row: newest samples.
      win_reg[8] <= ifmap_stream;
      win_reg[7] <= win_reg[8];
      win_reg[6] <= win_reg[7];
      // Middle row: one image row back.
      win_reg[5] <= line1_reg[IMG_WIDTH-1];
      win_reg[4] <= win_reg[5];
      win_reg[3] <= win_reg[4];
      // Top row: two image rows back.
      win_reg[2] <= line2_reg[IMG_WIDTH-1];
      win_reg[1] <= win_reg[2];
      win_reg[0] <= win_reg[1];

      col_reg     <= col_next;
      row_reg     <= row_next;
      started_reg <= 1'b1;
      valid_reg   <= valid_next;
    end
  end

  for (genvar gi = 0; gi < 9; gi++) begin : g_win_out
    assign ifmap_3x3[gi] = win_reg[gi];
  end

  assign window_valid = valid_reg;

endmodule

// File: tb/tb_linebuffer_3x3.sv
// tb_linebuffer_3x3: bench for linebuffer_3x3 with IMG_WIDTH = 4, DATA_W = 16.
// The reference model keeps every sample captured since the last reset in a
// queue. It forms the expected window directly from the index formula
// p(t - (2-r)*W - (2-c)), with out-of-range indices reading as zero.
module tb_linebuffer_3x3;
  localparam int DW = 16;
  localparam int W  = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [DW-1:0]       ifmap_stream = '0;
  logic [8:0][DW-1:0]  ifmap_3x3;
  logic                window_valid;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] hist [$];

  always #5 clk = ~clk;

  linebuffer_3x3 #(.DATA_W(DW), .IMG_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ifmap_stream (ifmap_stream),
    .ifmap_3x3    (ifmap_3x3),
    .window_valid (window_valid)
  );

  function automatic logic [8:0][DW-1:0] model_window();
    logic [8:0][DW-1:0] w;
    int t;
    int idx;
    t = int'(hist.size()) - 1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        idx = t - (2 - r) * W - (2 - c);
        w[r*3+c] = (idx < 0) ? '0 : hist[idx];
      end
    end
    return w;
  endfunction

  function automatic logic model_valid();
    int t;
    t = int'(hist.size()) - 1;
    return (t >= 0) && ((t % W) >= 2) && ((t / W) >= 2);
  endfunction

  task automatic check_win(input string tag, input logic [8:0][DW-1:0] exp);
    checks++;
    assert (ifmap_3x3 === exp) else begin
      errors++;
      $error("FAIL %s window: observed=%h expected=%h", tag, ifmap_3x3, exp);
    end
  endtask

  task automatic check_valid(input string tag, input logic exp);
    checks++;
    assert (window_valid === exp) else begin
      errors++;
      $error("FAIL %s valid: observed=%b expected=%b", tag, window_valid, exp);
    end
  endtask

  // Drive one sample, let one rising edge pass, compare against the model.
  task automatic step(input logic [DW-1:0] v, input string tag);
    @(negedge clk);
    ifmap_stream = v;
    @(posedge clk);
    if (rst_n) hist.push_back(v);
    #1;
    check_win(tag, model_window());
    check_valid(tag, model_valid());
    $display("%s rst_n=%b in=%h valid=%b win=%h", tag, rst_n, v, window_valid, ifmap_3x3);
  endtask

  // Reset pulse between clock edges; outputs must clear with no edge.
  task automatic reset_pulse(input string tag);
    #1;
    rst_n = 1'b0;
    hist.delete();
    #1;
    check_win(tag, '0);
    check_valid(tag, 1'b0);
    $display("%s async reset pulse", tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [16:0] vtab;
    vtab = 17'b1_1001_1000_0000_0000;  // expected valid for values 11..16

    // Reset held: captures are ignored, outputs stay zero.
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(16'hFFFF, "rst_hold");
      check_win("rst_hold_zero", '0);
    end

    // Counting stream 1..16.
    rst_n = 1'b1;
    for (int v = 1; v <= 16; v++) begin
      step(DW'(v), "count");
      if (v == 1) check_win("first", {16'd1, 128'd0});
      if (v == 2) check_win("second", {16'd2, 16'd1, 112'd0});
      if (v == 11) check_win("p11", {16'd11, 16'd10, 16'd9, 16'd7, 16'd6,
                                     16'd5, 16'd3, 16'd2, 16'd1});
      if (v == 16) check_win("p16", {16'd16, 16'd15, 16'd14, 16'd12, 16'd11,
                                     16'd10, 16'd8, 16'd7, 16'd6});
      if (v >= 11) check_valid("valid_tab", vtab[v]);
    end

    // Mid-stream asynchronous reset after capture of 9.
    reset_pulse("pulse_a");
    for (int v = 1; v <= 9; v++) step(DW'(v), "restart");
    reset_pulse("pulse_b");
    step(16'd10, "after_pulse");
    check_win("alone", {16'd10, 128'd0});
    check_valid("alone", 1'b0);

    // Random stream.
    for (int i = 0; i < 200; i++) step(DW'($urandom), "rand");

    // Reset held for several edges mid-stream, then resume.
    @(negedge clk);
    rst_n = 1'b0;
    hist.delete();
    for (int i = 0; i < 3; i++) step(DW'($urandom), "rand_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(DW'($urandom), "rand_resume");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
